// File: rtl/cgra_ctx_mem_responder.sv
// OBI slave for the CGRA context-memory window; read-modify-write for partial stores.
// Optional `CGRA_CTX_ERR_CAPTURE_EN adds a sticky out-of-range error capture.
module cgra_ctx_mem_responder #(
    parameter logic [31:0] START_ADDR  = 32'hF000_0000,
    parameter logic [31:0] WINDOW_SIZE = 32'h0010_0000,
    parameter int          MEM_DEPTH   = 1024,
    parameter logic [31:0] ERR_DATA    = 32'hBADC_AB1E,
    localparam int         AW          = $clog2(MEM_DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
`ifdef CGRA_CTX_ERR_CAPTURE_EN
    output logic          err_o,
    output logic [31:0]   err_addr_o,
    input  logic          err_clr_i,
`endif
    input  logic          req_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   addr_i,
    input  logic [31:0]   wdata_i,
    output logic          gnt_o,
    output logic          rvalid_o,
    output logic [31:0]   rdata_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i,
    input  logic          mem_busy_i
);

    typedef enum logic [1:0] {IDLE, RMW_MERGE, RMW_WRITE} state_t;

    state_t        state_q, state_d;
    logic [31:0]   offset;
    logic [32:0]   win_end;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          grant;

    logic          gnt, mreq, mwe;
    logic [AW-1:0] maddr;
    logic [31:0]   mwdata;
    logic          resp, resp_mem;
    logic [31:0]   resp_data;

    logic          rvalid_q, rd_mem_q;
    logic [31:0]   hold_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q, merged_q, merged_d;
    logic [3:0]    be_q;

    assign offset   = addr_i - START_ADDR;
    assign win_end  = {1'b0, START_ADDR} + {1'b0, WINDOW_SIZE};
    assign in_range = (addr_i >= START_ADDR)
                   && ({1'b0, addr_i} < win_end)
                   && (offset[31:2] < 30'(MEM_DEPTH));
    assign idx      = offset[AW+1:2];
    assign grant    = req_i && (state_q == IDLE) && !mem_busy_i;

    always_comb begin
        state_d   = state_q;
        gnt       = 1'b0;
        mreq      = 1'b0;
        mwe       = 1'b0;
        maddr     = '0;
        mwdata    = '0;
        resp      = 1'b0;
        resp_mem  = 1'b0;
        resp_data = '0;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    gnt  = 1'b1;
                    resp = 1'b1;
                    if (!in_range) begin
                        resp_data = we_i ? 32'h0 : ERR_DATA;
                    end else if (!we_i) begin
                        mreq     = 1'b1;
                        maddr    = idx;
                        resp_mem = 1'b1;
                    end else if (be_i == 4'hF) begin
                        mreq   = 1'b1;
                        mwe    = 1'b1;
                        maddr  = idx;
                        mwdata = wdata_i;
                    end else if (be_i != 4'h0) begin
                        // response deferred until the merged write lands
                        mreq    = 1'b1;
                        maddr   = idx;
                        resp    = 1'b0;
                        state_d = RMW_MERGE;
                    end
                end
            end
            RMW_MERGE: state_d = RMW_WRITE;
            RMW_WRITE: begin
                if (!mem_busy_i) begin
                    mreq    = 1'b1;
                    mwe     = 1'b1;
                    maddr   = idx_q;
                    mwdata  = merged_q;
                    resp    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        merged_d = '0;
        for (int b = 0; b < 4; b++) begin
            merged_d[8*b +: 8] = be_q[b] ? wdata_q[8*b +: 8]
                                         : mem_rdata_i[8*b +: 8];
        end
    end

    // Strobes are combinational; gating with reset forces them low at once.
    assign gnt_o       = rst_ni && gnt;
    assign mem_req_o   = rst_ni && mreq;
    assign mem_we_o    = rst_ni && mwe;
    assign mem_addr_o  = rst_ni ? maddr  : '0;
    assign mem_wdata_o = rst_ni ? mwdata : '0;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = (rvalid_q && rd_mem_q) ? mem_rdata_i : hold_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rvalid_q <= 1'b0;
            rd_mem_q <= 1'b0;
            hold_q   <= '0;
            idx_q    <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            merged_q <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= resp;
            rd_mem_q <= resp_mem;
            if (resp && !resp_mem) begin
                hold_q <= resp_data;
            end else if (rvalid_q && rd_mem_q) begin
                hold_q <= mem_rdata_i;
            end
            if (gnt && state_d == RMW_MERGE) begin
                idx_q   <= idx;
                wdata_q <= wdata_i;
                be_q    <= be_i;
            end
            if (state_q == RMW_MERGE) begin
                merged_q <= merged_d;
            end
        end
    end

`ifdef CGRA_CTX_ERR_CAPTURE_EN
    logic err_hit;
    assign err_hit = gnt && !in_range;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o      <= 1'b0;
            err_addr_o <= '0;
        end else if (err_hit && (!err_o || err_clr_i)) begin
            err_o      <= 1'b1;
            err_addr_o <= addr_i;
        end else if (err_clr_i) begin
            err_o      <= 1'b0;
            err_addr_o <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_cgra_ctx_mem_responder.sv
// Scoreboard bench for cgra_ctx_mem_responder with a behavioural 1-cycle SRAM.
// Directed vectors cover full/partial/empty writes, reads, range errors, busy and reset.
module tb_cgra_ctx_mem_responder;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [3:0]    be = 4'h0;
    logic [31:0]   addr = '0;
    logic [31:0]   wdata = '0;
    logic          gnt_o, rvalid_o, mem_req_o, mem_we_o;
    logic [31:0]   rdata_o, mem_wdata_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_rdata = '0;
    logic          busy = 1'b0;
`ifdef CGRA_CTX_ERR_CAPTURE_EN
    logic          err_o;
    logic [31:0]   err_addr_o;
    logic          err_clr = 1'b0;
`endif

    cgra_ctx_mem_responder dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
`ifdef CGRA_CTX_ERR_CAPTURE_EN
        .err_o       (err_o),
        .err_addr_o  (err_addr_o),
        .err_clr_i   (err_clr),
`endif
        .req_i       (req),
        .we_i        (we),
        .be_i        (be),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata),
        .mem_busy_i  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
        bit          after_wr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [1024];
    int          cyc = 0;
    int          wr_cyc = -10;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_req_o) begin
            if (mem_we_o) begin
                mem[mem_addr_o] <= mem_wdata_o;
                wr_cyc <= cyc;
            end else begin
                mem_rdata <= mem[mem_addr_o];
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_ni) begin
            if (busy) chk("busy_quiet", {30'h0, gnt_o, mem_req_o}, 32'h0);
            if (rvalid_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid: got rdata %h at cycle %0d expected none",
                             rdata_o, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("rdata", rdata_o, e.data);
                    chk("rvalid_cycle", cyc, e.after_wr ? wr_cyc + 1 : e.due);
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp, input bit push,
                         input bit exp_mreq, input bit rmw,
                         output int waited);
        waited = 0;
        @(negedge clk);
        req = 1'b1; we = w; be = b; addr = a; wdata = d;
        #1;
        while (!gnt_o && waited < 30) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!gnt_o) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: no grant for addr %h expected grant", a);
            req = 1'b0;
            return;
        end
        chk("mem_req_at_grant", {31'h0, mem_req_o}, {31'h0, exp_mreq});
        if (push) sb.push_back('{exp, cyc + 1, rmw});
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_gnt"}, {31'h0, gnt_o}, 32'h0);
        chk({tag, "_rvalid"}, {31'h0, rvalid_o}, 32'h0);
        chk({tag, "_rdata"}, rdata_o, 32'h0);
        chk({tag, "_mem_req"}, {30'h0, mem_req_o, mem_we_o}, 32'h0);
        chk({tag, "_mem_addr"}, {22'h0, mem_addr_o}, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata_o, 32'h0);
    endtask

    initial begin
        int w;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0] = 32'h1000_0000; mem[1] = 32'h1111_1111;
        mem[2] = 32'h2222_2222; mem[3] = 32'h3333_3333;
        mem[5] = 32'h5555_5555; mem[8] = 32'hAABB_CCDD;
        mem[9] = 32'h1122_3344; mem[12] = 32'h5566_7788;
        mem[1023] = 32'hCAFE_F00D;

        req = 1'b1; we = 1'b0; addr = 32'hF000_0000;
        #13;
        chk_zero_outputs("reset");
        req = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;

        // full write then read back
        issue(1, 4'hF, 32'hF000_0010, 32'h1234_5678, 32'h0, 1, 1, 0, w);
        issue(0, 4'hF, 32'hF000_0010, 32'h0, 32'h1234_5678, 1, 1, 0, w);
        chk("t1_grant_wait", w, 0);
        chk("t1_mem4", mem[4], 32'h1234_5678);

        // partial write merge, follow-up read waits two cycles
        issue(1, 4'b0010, 32'hF000_0020, 32'h0000_EE00, 32'h0, 1, 1, 1, w);
        issue(0, 4'hF, 32'hF000_0020, 32'h0, 32'hAABB_EEDD, 1, 1, 0, w);
        chk("t2_gnt_low_cycles", w, 2);
        chk("t2_mem8", mem[8], 32'hAABB_EEDD);

        // empty-byte-enable write touches nothing
        issue(1, 4'h0, 32'hF000_0014, 32'hFFFF_FFFF, 32'h0, 1, 0, 0, w);

        // back-to-back reads
        for (int i = 0; i < 4; i++) begin
            issue(0, 4'hF, 32'hF000_0000 + 32'(4 * i), 32'h0,
                  mem[i], 1, 1, 0, w);
            chk("t3_grant_wait", w, 0);
        end
        chk("t3_mem5_kept", mem[5], 32'h5555_5555);

        // window edges and out-of-range accesses
        issue(0, 4'hF, 32'hF000_0FFC, 32'h0, 32'hCAFE_F00D, 1, 1, 0, w);
        issue(0, 4'hF, 32'hF000_1000, 32'h0, 32'hBADC_AB1E, 1, 0, 0, w);
`ifdef CGRA_CTX_ERR_CAPTURE_EN
        @(negedge clk);
        chk("t4_err", {31'h0, err_o}, 32'h1);
        chk("t4_err_addr", err_addr_o, 32'hF000_1000);
`endif
        issue(1, 4'hF, 32'hF020_0000, 32'hDEAD_BEEF, 32'h0, 1, 0, 0, w);
        issue(0, 4'hF, 32'hEFFF_FFFC, 32'h0, 32'hBADC_AB1E, 1, 0, 0, w);
`ifdef CGRA_CTX_ERR_CAPTURE_EN
        @(negedge clk);
        chk("t4_err_addr_sticky", err_addr_o, 32'hF000_1000);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t4_err_cleared", {31'h0, err_o}, 32'h0);
`endif

        // busy during the RMW write with a new request pending
        issue(1, 4'b1000, 32'hF000_0024, 32'hAA00_0000, 32'h0, 1, 1, 1, w);
        fork
            begin
                @(negedge clk);
                busy = 1'b1;
                repeat (5) @(negedge clk);
                busy = 1'b0;
            end
            begin
                int w2;
                issue(0, 4'hF, 32'hF000_0024, 32'h0, 32'hAA22_3344, 1, 1, 0, w2);
                chk("t5_grant_wait", w2, 6);
            end
        join
        chk("t5_mem9", mem[9], 32'hAA22_3344);

        // reset pulse during RMW_MERGE aborts the write
        issue(1, 4'b0001, 32'hF000_0030, 32'h0000_0099, 32'h0, 0, 1, 1, w);
        rst_ni = 1'b0;
        #1;
        chk_zero_outputs("mid_rmw_reset");
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_mem12_kept", mem[12], 32'h5566_7788);
        issue(0, 4'hF, 32'hF000_0030, 32'h0, 32'h5566_7788, 1, 1, 0, w);
        chk("t6_grant_wait", w, 0);

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/cgra_ctx_mem_responder.md
Name: cgra_ctx_mem_responder

Overview:
OBI slave responder for the CGRA context-memory window on the external slave crossbar port. It is the other end of the CPU/DMA initiator traffic routed to the CGRA slave index.
- Decodes and range-checks addresses.
- Drives a single-port, word-wide context SRAM with 1-cycle read latency.
- Performs read-modify-write for partial-byte writes, because the context memory has no byte enables.
- Yields the SRAM port to the CGRA context fetcher whenever that fetcher is busy.

Parameters:
START_ADDR, 32'hF000_0000, base of the context-memory window (external slave start).
WINDOW_SIZE, 32'h0010_0000, decoded window size in bytes.
MEM_DEPTH, 1024, SRAM depth in 32-bit words; AW = $clog2(MEM_DEPTH).
ERR_DATA, 32'hBADC_AB1E, rdata returned for out-of-range reads.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  1  OBI request
we_i  in  1  OBI write enable
be_i  in  4  OBI byte enables
addr_i  in  32  OBI byte address
wdata_i  in  32  OBI write data
gnt_o  out  1  OBI grant
rvalid_o  out  1  OBI response valid
rdata_o  out  32  OBI read data
mem_req_o  out  1  SRAM access strobe
mem_we_o  out  1  SRAM write enable
mem_addr_o  out  AW  SRAM word address
mem_wdata_o  out  32  SRAM write data
mem_rdata_i  in  32  SRAM read data, valid the cycle after a read strobe
mem_busy_i  in  1  CGRA fetcher owns the SRAM this cycle

Behaviour:
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0; FSM in IDLE.
- Address decode:
  - offset = addr_i - START_ADDR; word index = offset[AW+1:2]; addr_i[1:0] ignored.
  - In range iff START_ADDR <= addr_i < START_ADDR+WINDOW_SIZE and offset>>2 < MEM_DEPTH.
  - Use 33-bit compare so the window end does not wrap.
- gnt_o = req_i & (state==IDLE) & ~mem_busy_i. This is combinational; at most one grant per cycle.
- Granted transaction classes at cycle T:
  - Read, in range: mem_req_o=1, mem_we_o=0 at T. rvalid_o=1 at T+1 with rdata_o=mem_rdata_i. Stay IDLE; back-to-back reads sustain 1/cycle.
  - Write, be=4'b1111, in range: mem write at T with wdata_i. rvalid_o=1 at T+1, rdata_o=0. Stay IDLE.
  - Write, be=4'b0000: no SRAM access; rvalid at T+1, rdata_o=0.
  - Write, partial be, in range:
    - At T: issue SRAM read, latch index/wdata/be, go to RMW_MERGE.
    - At T+1: merged = per-byte mux(be ? wdata : mem_rdata_i), stored in a register; go to RMW_WRITE.
    - RMW_WRITE: issue SRAM write of the merged word in the first cycle with ~mem_busy_i, then return to IDLE.
    - rvalid_o=1 the cycle after that write, rdata_o=0.
  - Out of range: no SRAM access; rvalid at T+1. Read returns rdata_o=ERR_DATA; write is dropped with rdata_o=0.
- FSM: IDLE -> RMW_MERGE (partial write granted) -> RMW_WRITE -> IDLE (write issued). RMW_MERGE always lasts exactly 1 cycle.
- gnt_o=0 in RMW_MERGE and RMW_WRITE.
- At most one RMW outstanding. Responses return in grant order, exactly one rvalid per grant.
- mem_busy_i:
  - Suppresses gnt_o and all SRAM strobes from this block.
  - An already-issued read still returns data at T+1.
  - mem_busy_i rising during RMW_MERGE does not affect the merge.
- rdata_o is held between responses; it is don't-care when rvalid_o=0.
- Reset asserted mid-RMW: the pending write is aborted and no rvalid is produced. The SRAM keeps the old word.

Optional Feature:
CGRA_CTX_ERR_CAPTURE_EN
- Defined: adds ports err_o (out, 1), err_addr_o (out, 32) and err_clr_i (in, 1).
  - The first out-of-range granted access sets err_o (sticky) and captures addr_i; later errors do not overwrite the captured address.
  - err_clr_i clears both outputs next cycle. If a new error coincides with the clear, the new error wins.
  - Reset value of both outputs is 0.
- Undefined: these ports and registers are absent; out-of-range behaviour is otherwise identical.

Test Plan:
1. Write 0x1234_5678 be=1111 to 0xF000_0010, then read it -> SRAM word 4 written. Read rvalid one cycle after its grant with rdata 0x1234_5678.
2. Word 8 = 0xAABB_CCDD; write 0x0000_EE00 be=0010 to 0xF000_0020 -> gnt low 2 cycles. SRAM then holds 0xAABB_EEDD; rvalid one cycle after the write strobe.
3. Four back-to-back reads to 0xF000_0000..0C with req held -> 4 grants in 4 cycles, rvalid on 4 consecutive cycles with in-order data.
4. Read 0xF000_1000 with MEM_DEPTH=1024 (index 1024) -> no mem_req_o, rvalid T+1, rdata 0xBADC_AB1E. With CGRA_CTX_ERR_CAPTURE_EN: err_o=1, err_addr_o=0xF000_1000.
5. mem_busy_i=1 for 5 cycles during RMW_WRITE and also with a new req pending -> write delayed until busy drops, gnt_o stays 0 throughout, no lost or duplicated rvalid.
6. rst_ni pulsed low during RMW_MERGE -> all outputs 0 immediately. No rvalid and no SRAM write after release; the next request is granted normally.
